// File: rtl/conv_ctrl_pkg.sv
// Shared opcodes, instruction field positions and controller
// state encoding for the convolution processor sequencer.
package conv_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_CONV = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int TGT_LO = 22;
  localparam int OPD_HI = 21;
  localparam int OPD_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

endpackage

// File: rtl/seq_timeout_counter.sv
// Bounded wait counter: expired is high in the TIMEOUT-th
// enabled cycle after a clear. TIMEOUT of 0 never expires.
module seq_timeout_counter #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller: drives the program counter
// strobes and launches ALU / CONV operations on the datapath.
module pc_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int INSTR_W  = 32,
  parameter int IMEM_LAT = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  input  logic               ex_done,
  output logic               pc_en,
  output logic               pc_w_en,
  output logic               pc_inc,
  output logic [31:0]        pc_data,
  output logic               pc_complete,
  output logic               ex_start,
  output logic [3:0]         ex_op,
  output logic [21:0]        ex_operand,
  output logic               busy,
  output logic               fault
);

  localparam int FW = (IMEM_LAT < 2) ? 1 : $clog2(IMEM_LAT);
  localparam logic [FW-1:0] FLAST = FW'(IMEM_LAT - 1);

  state_t             state;
  state_t             next;
  logic [INSTR_W-1:0] ir;
  logic [FW-1:0]      fetch_cnt;
  logic               fetch_last;
  logic               tmo_expired;
  logic [3:0]         op;

  assign op         = ir[OPC_HI:OPC_LO];
  assign fetch_last = (fetch_cnt == FLAST);

  seq_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != S_WAIT),
    .enable  (state == S_WAIT),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir        <= '0;
      fetch_cnt <= '0;
    end else begin
      state <= next;
      if (state == S_FETCH && fetch_last) begin
        ir <= instr;
      end
      if (state == S_FETCH && !fetch_last) begin
        fetch_cnt <= fetch_cnt + 1'b1;
      end else begin
        fetch_cnt <= '0;
      end
    end
  end

  always_comb begin
    next        = state;
    pc_w_en     = 1'b0;
    pc_inc      = 1'b0;
    pc_en       = 1'b0;
    pc_data     = '0;
    pc_complete = 1'b0;
    ex_start    = 1'b0;
    ex_op       = '0;
    ex_operand  = '0;
    busy        = 1'b1;
    fault       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next = S_LOAD0;
      end
      S_LOAD0: begin
        pc_w_en = 1'b1;
        next    = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_last) next = S_DECODE;
      end
      S_DECODE: begin
        next = S_FETCH;
        unique case (1'b1)
          op == OP_NOP: pc_inc = 1'b1;
          op == OP_ALU: begin
            ex_start = 1'b1;
            pc_inc   = 1'b1;
          end
          op == OP_CONV: begin
            ex_start = 1'b1;
            next     = S_WAIT;
          end
          op == OP_JMP: pc_w_en = 1'b1;
          op == OP_JZ: begin
            pc_w_en = zero_flag;
            pc_inc  = !zero_flag;
          end
          op == OP_HALT: next = S_HALT;
          default: next = S_FAULT;
        endcase
      end
      S_WAIT: begin
        // completion beats a simultaneous timeout
        if (ex_done) begin
          pc_inc = 1'b1;
          next   = S_FETCH;
        end else if (tmo_expired) begin
          next = S_FAULT;
        end
      end
      S_HALT: begin
        busy        = 1'b0;
        pc_complete = 1'b1;
        if (start) next = S_LOAD0;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
        if (start) next = S_LOAD0;
      end
      default: begin
        busy = 1'b0;
        next = S_IDLE;
      end
    endcase
    pc_en = pc_w_en | pc_inc;
    if (pc_w_en && state == S_DECODE) begin
      pc_data = 32'(ir[TGT_LO +: ADDR_W]);
    end
    if (ex_start) begin
      ex_op      = op;
      ex_operand = ir[OPD_HI:OPD_LO];
    end
  end

endmodule
